tcp_tx_pkt_out_queue: RTL and testbench

- Downstream neighbour of the TCP TX protocol-calc stage.
- Accepts one finished packet descriptor per handshake: TCP header, flowid, IP addresses and payload buffer descriptor.
- Buffers descriptors in a small FIFO.
- For each packet, issues two requests:
  - a header/metadata request to the IP/NoC packet assembler;
  - a payload-read request to the TX payload buffer.
- Decouples protocol calculation from output backpressure.

---
 rtl/tcp_tx_pkt_out_queue_pkg.sv | 33 +++
 rtl/tcp_tx_pkt_out_queue_if.sv | 45 ++++
 rtl/tcp_tx_pkt_out_queue_desc_fifo.sv | 46 ++++
 rtl/tcp_tx_pkt_out_queue.sv | 68 ++++++
 tb/tb_tcp_tx_pkt_out_queue.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tcp_tx_pkt_out_queue_pkg.sv
// tcp_tx_pkt_out_queue_pkg: shared TCP TX types and widths for the packet output queue
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_tx_pkt_out_queue_pkg;
    localparam int FLOWID_W = 8;
    localparam int TX_PAYLOAD_PTR_W = 16;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [TX_PAYLOAD_PTR_W-1:0] payload_addr;
        logic [TX_PAYLOAD_PTR_W:0]   payload_len;
    } smol_payload_buf_struct;

    typedef struct packed {
        tcp_pkt_hdr             hdr;
        logic [FLOWID_W-1:0]    flowid;
        logic [`IP_ADDR_W-1:0]  src_ip;
        logic [`IP_ADDR_W-1:0]  dst_ip;
        smol_payload_buf_struct payload;
    } tx_pkt_desc_struct;

    localparam int DESC_W = $bits(tx_pkt_desc_struct);
endpackage

// File: rtl/tcp_tx_pkt_out_queue_if.sv
// tcp_tx_pkt_out_queue_if: descriptor input, header request and payload read request channels
interface tcp_tx_pkt_out_queue_if
    import tcp_tx_pkt_out_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int DEPTH_W = $clog2(DEPTH);

    logic                        src_pkt_out_val;
    logic                        src_pkt_out_rdy;
    tcp_pkt_hdr                  src_pkt_out_hdr;
    logic [FLOWID_W-1:0]         src_pkt_out_flowid;
    logic [`IP_ADDR_W-1:0]       src_pkt_out_src_ip;
    logic [`IP_ADDR_W-1:0]       src_pkt_out_dst_ip;
    smol_payload_buf_struct      src_pkt_out_payload;
    logic                        hdr_out_val;
    logic                        hdr_out_rdy;
    tcp_pkt_hdr                  hdr_out_hdr;
    logic [FLOWID_W-1:0]         hdr_out_flowid;
    logic [`IP_ADDR_W-1:0]       hdr_out_src_ip;
    logic [`IP_ADDR_W-1:0]       hdr_out_dst_ip;
    logic [TX_PAYLOAD_PTR_W:0]   hdr_out_payload_len;
    logic                        payload_rd_req_val;
    logic                        payload_rd_req_rdy;
    logic [FLOWID_W-1:0]         payload_rd_req_flowid;
    logic [TX_PAYLOAD_PTR_W-1:0] payload_rd_req_addr;
    logic [TX_PAYLOAD_PTR_W:0]   payload_rd_req_len;
    logic [DEPTH_W:0]            occupancy;

    modport master (
        output src_pkt_out_val, src_pkt_out_hdr, src_pkt_out_flowid, src_pkt_out_src_ip,
               src_pkt_out_dst_ip, src_pkt_out_payload, hdr_out_rdy, payload_rd_req_rdy,
        input  src_pkt_out_rdy, hdr_out_val, hdr_out_hdr, hdr_out_flowid, hdr_out_src_ip,
               hdr_out_dst_ip, hdr_out_payload_len, payload_rd_req_val, payload_rd_req_flowid,
               payload_rd_req_addr, payload_rd_req_len, occupancy
    );

    modport slave (
        input  src_pkt_out_val, src_pkt_out_hdr, src_pkt_out_flowid, src_pkt_out_src_ip,
               src_pkt_out_dst_ip, src_pkt_out_payload, hdr_out_rdy, payload_rd_req_rdy,
        output src_pkt_out_rdy, hdr_out_val, hdr_out_hdr, hdr_out_flowid, hdr_out_src_ip,
               hdr_out_dst_ip, hdr_out_payload_len, payload_rd_req_val, payload_rd_req_flowid,
               payload_rd_req_addr, payload_rd_req_len, occupancy
    );
endinterface

// File: rtl/tcp_tx_pkt_out_queue_desc_fifo.sv
// tcp_tx_desc_fifo: registered descriptor FIFO with head read and explicit yank
module tcp_tx_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int DEPTH_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_val,
    output logic             wr_rdy,
    input  logic [W-1:0]     wr_data,
    output logic             rd_val,
    output logic [W-1:0]     rd_data,
    input  logic             rd_yank,
    output logic [DEPTH_W:0] count
);
    logic [W-1:0]       mem [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic               push;
    logic               pop;

    assign wr_rdy  = count != (DEPTH_W+1)'(DEPTH);
    assign rd_val  = count != '0;
    assign rd_data = mem[rd_ptr];
    assign push    = wr_val & wr_rdy;
    assign pop     = rd_yank & rd_val;

    // pointer and count bookkeeping; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_W'(push);
            rd_ptr <= rd_ptr + DEPTH_W'(pop);
            count  <= count + (DEPTH_W+1)'(push) - (DEPTH_W+1)'(pop);
        end
    end

    // descriptor storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/tcp_tx_pkt_out_queue.sv
// tcp_tx_pkt_out_queue: buffers TX descriptors and issues header + payload-read requests per packet
// Optional TCP_TX_PKT_OUT_STRICT_ORDER_EN: payload read waits until the header handshake has completed.
module tcp_tx_pkt_out_queue
    import tcp_tx_pkt_out_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    tcp_tx_pkt_out_queue_if.slave q_if
);
    tx_pkt_desc_struct wr_desc;
    tx_pkt_desc_struct head;
    logic rd_val;
    logic yank;
    logic hdr_sent;
    logic pld_sent;
    logic need_pld;
    logic hdr_fire;
    logic pld_fire;

    assign wr_desc = '{hdr: q_if.src_pkt_out_hdr, flowid: q_if.src_pkt_out_flowid,
                       src_ip: q_if.src_pkt_out_src_ip, dst_ip: q_if.src_pkt_out_dst_ip,
                       payload: q_if.src_pkt_out_payload};

    tcp_tx_desc_fifo #(.DEPTH(DEPTH), .W(DESC_W)) fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_val  (q_if.src_pkt_out_val),
        .wr_rdy  (q_if.src_pkt_out_rdy),
        .wr_data (wr_desc),
        .rd_val  (rd_val),
        .rd_data (head),
        .rd_yank (yank),
        .count   (q_if.occupancy)
    );

    assign need_pld = head.payload.payload_len != '0;
    assign q_if.hdr_out_val = rd_val & ~hdr_sent;
`ifdef TCP_TX_PKT_OUT_STRICT_ORDER_EN
    assign q_if.payload_rd_req_val = rd_val & ~pld_sent & need_pld & hdr_sent;
`else
    assign q_if.payload_rd_req_val = rd_val & ~pld_sent & need_pld;
`endif
    assign hdr_fire = q_if.hdr_out_val & q_if.hdr_out_rdy;
    assign pld_fire = q_if.payload_rd_req_val & q_if.payload_rd_req_rdy;
    assign yank     = rd_val & (hdr_sent | hdr_fire) & (pld_sent | pld_fire | ~need_pld);

    assign q_if.hdr_out_hdr           = head.hdr;
    assign q_if.hdr_out_flowid        = head.flowid;
    assign q_if.hdr_out_src_ip        = head.src_ip;
    assign q_if.hdr_out_dst_ip        = head.dst_ip;
    assign q_if.hdr_out_payload_len   = head.payload.payload_len;
    assign q_if.payload_rd_req_flowid = head.flowid;
    assign q_if.payload_rd_req_addr   = head.payload.payload_addr;
    assign q_if.payload_rd_req_len    = head.payload.payload_len;

    // per-head issue flags: remember completed handshakes until the entry pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_sent <= 1'b0;
            pld_sent <= 1'b0;
        end else begin
            hdr_sent <= yank ? 1'b0 : hdr_sent | hdr_fire;
            pld_sent <= yank ? 1'b0 : pld_sent | pld_fire;
        end
    end
endmodule

// File: tb/tb_tcp_tx_pkt_out_queue.sv
// tb_tcp_tx_pkt_out_queue: directed and random checks of the TX packet output queue against a queue model
module tb_tcp_tx_pkt_out_queue;
    import tcp_tx_pkt_out_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_assert = 0;
    int n_fail = 0;

    tx_pkt_desc_struct q[$];
    logic [FLOWID_W-1:0] fired[$];
    bit hs = 0;
    bit ps = 0;

    tcp_tx_pkt_out_queue_if #(.DEPTH(DEPTH)) dut_if ();
    tcp_tx_pkt_out_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q_if(dut_if.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tx_pkt_desc_struct mk(input logic [7:0] fid, input logic [16:0] len,
                                             input logic [15:0] addr);
        tx_pkt_desc_struct d;
        d.hdr.src_port = 16'($urandom);
        d.hdr.dst_port = 16'($urandom);
        d.hdr.seq_num = $urandom;
        d.hdr.ack_num = $urandom;
        d.hdr.flags = 8'($urandom);
        d.hdr.window = 16'($urandom);
        d.flowid = fid;
        d.src_ip = $urandom;
        d.dst_ip = $urandom;
        d.payload.payload_addr = addr;
        d.payload.payload_len = len;
        return d;
    endfunction

    task automatic drive(input tx_pkt_desc_struct d, input bit val);
        dut_if.src_pkt_out_val = val;
        dut_if.src_pkt_out_hdr = d.hdr;
        dut_if.src_pkt_out_flowid = d.flowid;
        dut_if.src_pkt_out_src_ip = d.src_ip;
        dut_if.src_pkt_out_dst_ip = d.dst_ip;
        dut_if.src_pkt_out_payload = d.payload;
    endtask

    task automatic set_rdy(input bit h, input bit p);
        dut_if.hdr_out_rdy = h;
        dut_if.payload_rd_req_rdy = p;
    endtask

    // one clock: compare outputs with the model, then advance the model by the handshakes seen
    task automatic tick(output bit pushed);
        bit ev_h, ev_p, hf, pf, push, zero;
        #1;
        ev_h = q.size() > 0 && !hs;
        zero = q.size() > 0 && q[0].payload.payload_len == 0;
        ev_p = q.size() > 0 && !ps && !zero;
`ifdef TCP_TX_PKT_OUT_STRICT_ORDER_EN
        ev_p = ev_p && hs;
`endif
        chk("src_rdy", 128'(dut_if.src_pkt_out_rdy), 128'(q.size() < DEPTH));
        chk("occupancy", 128'(dut_if.occupancy), 128'(q.size()));
        chk("hdr_val", 128'(dut_if.hdr_out_val), 128'(ev_h));
        chk("pld_val", 128'(dut_if.payload_rd_req_val), 128'(ev_p));
        if (ev_h) begin
            chk("hdr_hdr", 128'(dut_if.hdr_out_hdr), 128'(q[0].hdr));
            chk("hdr_flowid", 128'(dut_if.hdr_out_flowid), 128'(q[0].flowid));
            chk("hdr_src_ip", 128'(dut_if.hdr_out_src_ip), 128'(q[0].src_ip));
            chk("hdr_dst_ip", 128'(dut_if.hdr_out_dst_ip), 128'(q[0].dst_ip));
            chk("hdr_len", 128'(dut_if.hdr_out_payload_len), 128'(q[0].payload.payload_len));
        end
        if (ev_p) begin
            chk("pld_flowid", 128'(dut_if.payload_rd_req_flowid), 128'(q[0].flowid));
            chk("pld_addr", 128'(dut_if.payload_rd_req_addr), 128'(q[0].payload.payload_addr));
            chk("pld_len", 128'(dut_if.payload_rd_req_len), 128'(q[0].payload.payload_len));
        end
        push = dut_if.src_pkt_out_val && q.size() < DEPTH;
        hf = ev_h && dut_if.hdr_out_rdy;
        pf = ev_p && dut_if.payload_rd_req_rdy;
        @(posedge clk);
        if (hf) fired.push_back(q[0].flowid);
        if (q.size() > 0 && (hs || hf) && (ps || pf || zero)) begin
            void'(q.pop_front());
            hs = 0;
            ps = 0;
        end else begin
            hs = hs || hf;
            ps = ps || pf;
        end
        if (push) q.push_back(tx_pkt_desc_struct'({dut_if.src_pkt_out_hdr, dut_if.src_pkt_out_flowid,
                                                   dut_if.src_pkt_out_src_ip, dut_if.src_pkt_out_dst_ip,
                                                   dut_if.src_pkt_out_payload}));
        @(negedge clk);
        pushed = push;
    endtask

    task automatic push_one(input tx_pkt_desc_struct d);
        bit p = 0;
        drive(d, 1'b1);
        for (int i = 0; i < 40 && !p; i++) tick(p);
        chk("push_accepted", 128'(p), 128'(1));
        dut_if.src_pkt_out_val = 1'b0;
    endtask

    task automatic drain();
        bit p;
        dut_if.src_pkt_out_val = 1'b0;
        set_rdy(1'b1, 1'b1);
        for (int i = 0; i < 40 && q.size() > 0; i++) tick(p);
        chk("drain_occupancy", 128'(dut_if.occupancy), 128'(0));
    endtask

    initial begin
        bit p;
        drive(mk(0, 0, 0), 1'b0);
        set_rdy(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_hdr_val", 128'(dut_if.hdr_out_val), 128'(0));
        chk("rst_pld_val", 128'(dut_if.payload_rd_req_val), 128'(0));
        chk("rst_occupancy", 128'(dut_if.occupancy), 128'(0));
        rst = 1'b1;
        #1;
        chk("rst_src_rdy", 128'(dut_if.src_pkt_out_rdy), 128'(1));
        @(negedge clk);

        // zero-length payload: header only, entry gone by N+2
        set_rdy(1'b1, 1'b1);
        push_one(mk(8'h21, 0, 16'h40));
        chk("zl_hdr_val", 128'(dut_if.hdr_out_val), 128'(1));
        chk("zl_pld_val", 128'(dut_if.payload_rd_req_val), 128'(0));
        tick(p);
        chk("zl_occupancy", 128'(dut_if.occupancy), 128'(0));
        chk("zl_pld_val_after", 128'(dut_if.payload_rd_req_val), 128'(0));

        // payload backpressure held for five cycles while the header goes through
        set_rdy(1'b1, 1'b0);
        fired.delete();
        push_one(mk(8'h33, 64, 16'h100));
`ifdef TCP_TX_PKT_OUT_STRICT_ORDER_EN
        tick(p);
`endif
        for (int i = 0; i < 5; i++) begin
            chk("bp_pld_val", 128'(dut_if.payload_rd_req_val), 128'(1));
            chk("bp_pld_addr", 128'(dut_if.payload_rd_req_addr), 128'(16'h100));
            chk("bp_pld_len", 128'(dut_if.payload_rd_req_len), 128'(64));
            tick(p);
        end
        chk("bp_hdr_once", 128'(fired.size()), 128'(1));
        set_rdy(1'b1, 1'b1);
        tick(p);
        chk("bp_popped", 128'(dut_if.occupancy), 128'(0));

        // fill to DEPTH, hold the fifth push, then drain in order
        set_rdy(1'b0, 1'b0);
        fired.delete();
        for (int k = 1; k <= 4; k++) push_one(mk(8'(k), 17'(k * 8), 16'(k * 16'h200)));
        drive(mk(5, 0, 16'h0), 1'b1);
        tick(p);
        tick(p);
        chk("full_occupancy", 128'(dut_if.occupancy), 128'(4));
        chk("full_src_rdy", 128'(dut_if.src_pkt_out_rdy), 128'(0));
        set_rdy(1'b1, 1'b1);
        p = 0;
        for (int i = 0; i < 40 && !p; i++) tick(p);
        chk("full_fifth_pushed", 128'(p), 128'(1));
        drain();
        chk("full_order_count", 128'(fired.size()), 128'(5));
        for (int k = 0; k < 5 && k < fired.size(); k++) chk("full_order", 128'(fired[k]), 128'(k + 1));

        // push lands on the same edge the head pops
        set_rdy(1'b0, 1'b0);
        fired.delete();
        push_one(mk(8'h10, 0, 0));
        push_one(mk(8'h11, 0, 0));
        set_rdy(1'b1, 1'b1);
        drive(mk(8'h12, 0, 0), 1'b1);
        tick(p);
        chk("sim_pushed", 128'(p), 128'(1));
        chk("sim_occupancy", 128'(dut_if.occupancy), 128'(2));
        drain();
        chk("sim_order_count", 128'(fired.size()), 128'(3));
        for (int k = 0; k < 3 && k < fired.size(); k++) chk("sim_order", 128'(fired[k]), 128'(8'h10 + k));

        // asynchronous reset with a half-issued head
        set_rdy(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) push_one(mk(8'h40 + 8'(k), 40, 16'h300));
        set_rdy(1'b1, 1'b0);
        tick(p);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_hdr_val", 128'(dut_if.hdr_out_val), 128'(0));
        chk("mid_rst_pld_val", 128'(dut_if.payload_rd_req_val), 128'(0));
        chk("mid_rst_occupancy", 128'(dut_if.occupancy), 128'(0));
        q.delete();
        hs = 0;
        ps = 0;
        @(negedge clk);
        rst = 1'b1;
        set_rdy(1'b1, 1'b1);
        repeat (4) tick(p);

        // strict-order timing: header at N+1, payload at N+2 only when strict
        push_one(mk(8'h55, 32, 16'h80));
        chk("so_hdr_val", 128'(dut_if.hdr_out_val), 128'(1));
`ifdef TCP_TX_PKT_OUT_STRICT_ORDER_EN
        chk("so_pld_n1", 128'(dut_if.payload_rd_req_val), 128'(0));
        tick(p);
        chk("so_pld_n2", 128'(dut_if.payload_rd_req_val), 128'(1));
`else
        chk("so_pld_n1", 128'(dut_if.payload_rd_req_val), 128'(1));
`endif
        drain();

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(mk(8'($urandom), ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom_range(1, 1500)),
                     16'($urandom)), 1'($urandom_range(0, 1)));
            set_rdy($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
            tick(p);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
